// File: rtl/bcd_counter_n.sv
// Multi-digit BCD up/down counter with load, clear, wrap/saturate boundary
// handling, a combinational cascade terminal count and a sticky overflow flag.
module bcd_counter_n #(
  parameter int DIGITS   = 4,
  parameter bit SATURATE = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  up_dn,
  input  logic                  clear,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  tc,
  output logic                  ovf,
  output logic                  load_err
);

  logic                  all9;
  logic                  all0;
  logic                  at_bound;
  logic                  carry;
  logic                  any_clamp;
  logic [3:0]            dig;
  logic [3:0]            ld_dig;
  logic [4*DIGITS-1:0]   step_val;
  logic [4*DIGITS-1:0]   load_fixed;

  // Non-BCD load digits are forced to 9 so bcd_out never shows 10..15
  function automatic logic [3:0] clamp_digit(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  function automatic logic [3:0] inc_digit(input logic [3:0] d);
    return (d == 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

  function automatic logic [3:0] dec_digit(input logic [3:0] d);
    return (d == 4'd0) ? 4'd9 : d - 4'd1;
  endfunction

  // Ripple the carry/borrow through all digits and build the clamped load value
  always_comb begin
    all9       = 1'b1;
    all0       = 1'b1;
    carry      = 1'b1;
    any_clamp  = 1'b0;
    dig        = 4'd0;
    ld_dig     = 4'd0;
    step_val   = '0;
    load_fixed = '0;
    for (int i = 0; i < DIGITS; i++) begin
      dig    = bcd_out[4*i +: 4];
      ld_dig = load_val[4*i +: 4];
      all9   = all9 & (dig == 4'd9);
      all0   = all0 & (dig == 4'd0);
      if (carry) begin
        step_val[4*i +: 4] = up_dn ? inc_digit(dig) : dec_digit(dig);
      end else begin
        step_val[4*i +: 4] = dig;
      end
      // A higher digit moves only while every lower digit sits at the rollover value
      carry = carry & (up_dn ? (dig == 4'd9) : (dig == 4'd0));
      load_fixed[4*i +: 4] = clamp_digit(ld_dig);
      any_clamp = any_clamp | (ld_dig > 4'd9);
    end
  end

  // Terminal count: the next enabled step crosses the all-9s / all-0s boundary
  always_comb begin
    at_bound = up_dn ? all9 : all0;
    tc       = en & at_bound;
  end

  // Count register with clear > load > en priority
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bcd_out  <= '0;
      ovf      <= 1'b0;
      load_err <= 1'b0;
    end else if (clear) begin
      bcd_out  <= '0;
      ovf      <= 1'b0;
      load_err <= 1'b0;
    end else if (load) begin
      bcd_out  <= load_fixed;
      ovf      <= 1'b0;
      load_err <= any_clamp;
    end else begin
      load_err <= 1'b0;
      if (en) begin
        if (at_bound) begin
          ovf <= 1'b1;
          // Wrapping falls out of the digit ripple; saturation just holds the value
          if (!SATURATE) begin
            bcd_out <= step_val;
          end
        end else begin
          bcd_out <= step_val;
        end
      end
    end
  end

endmodule

// File: tb/tb_bcd_counter_n.sv
// Directed bench for bcd_counter_n: one wrapping and one saturating instance
// share the same stimulus; each task checks the instance it is about.
module tb_bcd_counter_n;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b0;
  logic        up_dn = 1'b1;
  logic        clear = 1'b0;
  logic        load = 1'b0;
  logic [15:0] load_val = 16'h0000;
  logic [15:0] bcd0, bcd1;
  logic        tc0, tc1, ovf0, ovf1, lerr0, lerr1;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  bcd_counter_n #(.DIGITS(4), .SATURATE(1'b0)) dut_wrap (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .clear(clear),
    .load(load), .load_val(load_val), .bcd_out(bcd0), .tc(tc0),
    .ovf(ovf0), .load_err(lerr0)
  );

  bcd_counter_n #(.DIGITS(4), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .clear(clear),
    .load(load), .load_val(load_val), .bcd_out(bcd1), .tc(tc1),
    .ovf(ovf1), .load_err(lerr1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] v);
    load = 1'b1; load_val = v; en = 1'b0;
    tick();
    load = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
    #1;
    total_cnt++; if (bcd0 !== 16'h0000) $display("FAIL reset_bcd got %h want 0000", bcd0); else pass_cnt++;
    total_cnt++; if (ovf0 !== 1'b0) $display("FAIL reset_ovf got %b want 0", ovf0); else pass_cnt++;
    total_cnt++; if (lerr0 !== 1'b0) $display("FAIL reset_lerr got %b want 0", lerr0); else pass_cnt++;
  endtask

  task automatic test_count_up();
    logic [15:0] exp_v;
    en = 1'b1; up_dn = 1'b1;
    #1;
    for (int i = 1; i <= 10; i++) begin
      total_cnt++; if (tc0 !== 1'b0) $display("FAIL up_tc step %0d got %b want 0", i, tc0); else pass_cnt++;
      tick();
      exp_v = (i == 10) ? 16'h0010 : 16'(i);
      total_cnt++; if (bcd0 !== exp_v) $display("FAIL up_bcd step %0d got %h want %h", i, bcd0, exp_v); else pass_cnt++;
      total_cnt++; if (ovf0 !== 1'b0) $display("FAIL up_ovf step %0d got %b want 0", i, ovf0); else pass_cnt++;
    end
    en = 1'b0;
  endtask

  task automatic test_ripple();
    do_load(16'h0999);
    total_cnt++; if (bcd0 !== 16'h0999) $display("FAIL load_0999 got %h want 0999", bcd0); else pass_cnt++;
    en = 1'b1; up_dn = 1'b1;
    tick();
    total_cnt++; if (bcd0 !== 16'h1000) $display("FAIL ripple_up got %h want 1000", bcd0); else pass_cnt++;
    do_load(16'h1000);
    en = 1'b1; up_dn = 1'b0;
    tick();
    total_cnt++; if (bcd0 !== 16'h0999) $display("FAIL ripple_down got %h want 0999", bcd0); else pass_cnt++;
    en = 1'b0;
  endtask

  task automatic test_hold();
    do_load(16'h0457);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      up_dn = ~up_dn;
      tick();
    end
    total_cnt++; if (bcd0 !== 16'h0457) $display("FAIL hold_bcd got %h want 0457", bcd0); else pass_cnt++;
    en = 1'b1; up_dn = 1'b0;
    tick();
    total_cnt++; if (bcd0 !== 16'h0456) $display("FAIL hold_then_down got %h want 0456", bcd0); else pass_cnt++;
    en = 1'b0;
  endtask

  task automatic test_boundary();
    do_load(16'h9999);
    en = 1'b1; up_dn = 1'b1;
    #1;
    total_cnt++; if (tc0 !== 1'b1) $display("FAIL bound_tc_up got %b want 1", tc0); else pass_cnt++;
    tick();
    total_cnt++; if (bcd0 !== 16'h0000) $display("FAIL wrap_up_bcd got %h want 0000", bcd0); else pass_cnt++;
    total_cnt++; if (ovf0 !== 1'b1) $display("FAIL wrap_up_ovf got %b want 1", ovf0); else pass_cnt++;
    total_cnt++; if (bcd1 !== 16'h9999) $display("FAIL sat_up_bcd got %h want 9999", bcd1); else pass_cnt++;
    total_cnt++; if (ovf1 !== 1'b1) $display("FAIL sat_up_ovf got %b want 1", ovf1); else pass_cnt++;
    tick(); tick();
    total_cnt++; if (bcd0 !== 16'h0002) $display("FAIL wrap_continue got %h want 0002", bcd0); else pass_cnt++;
    total_cnt++; if (ovf0 !== 1'b1) $display("FAIL ovf_sticky got %b want 1", ovf0); else pass_cnt++;
    total_cnt++; if (bcd1 !== 16'h9999) $display("FAIL sat_hold3 got %h want 9999", bcd1); else pass_cnt++;
    do_load(16'h0000);
    total_cnt++; if (ovf0 !== 1'b0) $display("FAIL load_clears_ovf got %b want 0", ovf0); else pass_cnt++;
    en = 1'b1; up_dn = 1'b0;
    #1;
    total_cnt++; if (tc0 !== 1'b1) $display("FAIL bound_tc_down got %b want 1", tc0); else pass_cnt++;
    tick();
    total_cnt++; if (bcd0 !== 16'h9999) $display("FAIL wrap_down_bcd got %h want 9999", bcd0); else pass_cnt++;
    total_cnt++; if (ovf0 !== 1'b1) $display("FAIL wrap_down_ovf got %b want 1", ovf0); else pass_cnt++;
    total_cnt++; if (bcd1 !== 16'h0000) $display("FAIL sat_down_bcd got %h want 0000", bcd1); else pass_cnt++;
    total_cnt++; if (ovf1 !== 1'b1) $display("FAIL sat_down_ovf got %b want 1", ovf1); else pass_cnt++;
    en = 1'b0;
  endtask

  task automatic test_load_clamp();
    do_load(16'h1AF4);
    total_cnt++; if (bcd0 !== 16'h1994) $display("FAIL clamp_bcd got %h want 1994", bcd0); else pass_cnt++;
    total_cnt++; if (lerr0 !== 1'b1) $display("FAIL clamp_lerr got %b want 1", lerr0); else pass_cnt++;
    total_cnt++; if (ovf0 !== 1'b0) $display("FAIL clamp_ovf got %b want 0", ovf0); else pass_cnt++;
    tick();
    total_cnt++; if (lerr0 !== 1'b0) $display("FAIL lerr_one_cycle got %b want 0", lerr0); else pass_cnt++;
    total_cnt++; if (bcd0 !== 16'h1994) $display("FAIL clamp_hold got %h want 1994", bcd0); else pass_cnt++;
    do_load(16'h1234);
    total_cnt++; if (bcd0 !== 16'h1234) $display("FAIL load_1234 got %h want 1234", bcd0); else pass_cnt++;
    total_cnt++; if (lerr0 !== 1'b0) $display("FAIL load_1234_lerr got %b want 0", lerr0); else pass_cnt++;
  endtask

  task automatic test_priority_reset();
    do_load(16'h0042);
    clear = 1'b1; load = 1'b1; load_val = 16'h5555; en = 1'b1; up_dn = 1'b1;
    tick();
    clear = 1'b0; load = 1'b0; en = 1'b0;
    total_cnt++; if (bcd0 !== 16'h0000) $display("FAIL clear_prio got %h want 0000", bcd0); else pass_cnt++;
    do_load(16'h9999);
    en = 1'b1; up_dn = 1'b1;
    tick();
    do_load(16'h0316);
    en = 1'b1; up_dn = 1'b1;
    tick();
    total_cnt++; if (bcd0 !== 16'h0317) $display("FAIL reach_0317 got %h want 0317", bcd0); else pass_cnt++;
    total_cnt++; if (ovf1 !== 1'b0) $display("FAIL pre_reset_ovf1 got %b want 0", ovf1); else pass_cnt++;
    #2;
    reset = 1'b0;
    #1;
    total_cnt++; if (bcd0 !== 16'h0000) $display("FAIL async_reset_bcd got %h want 0000", bcd0); else pass_cnt++;
    total_cnt++; if (ovf0 !== 1'b0) $display("FAIL async_reset_ovf got %b want 0", ovf0); else pass_cnt++;
    tick();
    total_cnt++; if (bcd0 !== 16'h0000) $display("FAIL reset_held got %h want 0000", bcd0); else pass_cnt++;
    #2;
    reset = 1'b1;
    tick();
    total_cnt++; if (bcd0 !== 16'h0001) $display("FAIL resume_up got %h want 0001", bcd0); else pass_cnt++;
    en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_ripple();
    test_hold();
    test_boundary();
    test_load_clamp();
    test_priority_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/bcd_counter_n.md
Name: bcd_counter_n

Overview:
- Parametrised multi-digit BCD up/down counter; successor to the single-digit BCD counter.
- Each digit stays in 0..9. Carries and borrows ripple between digits within one clock.
- Adds load, synchronous clear, count direction, wrap or saturate mode, a cascade terminal-count output and a sticky overflow flag.
- Drives display decoders and timer blocks in the experiment designs. Instances cascade through en/tc.

Parameters:
- DIGITS, 4, number of BCD digits (1..8); digit 0 is least significant, at bits [3:0].
- SATURATE, 0, 0 = wrap at the boundary (9..9 -> 0..0 up, 0..0 -> 9..9 down); 1 = hold at the boundary.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- en  input  1  count enable; one step per clock while high.
- up_dn  input  1  1 = count up, 0 = count down; sampled only when a step occurs.
- clear  input  1  synchronous clear to zero.
- load  input  1  synchronous parallel load.
- load_val  input  4*DIGITS  BCD value to load.
- bcd_out  output  4*DIGITS  current count, registered.
- tc  output  1  combinational terminal count, for cascading.
- ovf  output  1  sticky overflow/underflow flag, registered.
- load_err  output  1  one-cycle flag: the last load contained a non-BCD digit.

Behaviour:
- Reset (reset=0, any time, asynchronous): bcd_out=0, ovf=0, load_err=0.
  - Reset overrides everything, including a step in progress.
  - The first step after reset deasserts applies from value 0.
- Priority per rising edge: clear > load > en. Only one action per cycle.
- clear=1:
  - bcd_out=0, ovf=0, load_err=0.
  - load and en are ignored that cycle.
- load=1 (clear=0):
  - Each digit of load_val with value <=9 is loaded as-is.
  - Each digit with value 10..15 is loaded as 9.
  - load_err=1 for exactly the next cycle if any digit was clamped, else 0.
  - ovf is cleared.
  - en is ignored that cycle.
- load_err is 0 in every cycle not directly following a clamped load.
- en=1, up_dn=1 (count up):
  - Digit 0 increments.
  - Digit k increments only when all lower digits equal 9. Those lower digits become 0.
  - A digit at 9 that increments becomes 0.
- en=1, up_dn=0 (count down):
  - Digit 0 decrements.
  - Digit k decrements only when all lower digits equal 0. Those lower digits become 9.
  - A digit at 0 that decrements becomes 9.
- Boundary, counting up from all-9s:
  - SATURATE=0: next value is all 0s.
  - SATURATE=1: value holds at all-9s.
  - In both modes ovf is set to 1 on that edge.
- Boundary, counting down from all-0s:
  - SATURATE=0: next value is all 9s.
  - SATURATE=1: value holds at all-0s.
  - In both modes ovf is set to 1 on that edge.
- ovf stays 1 until reset, clear or load.
- en=0 and no clear or load: all state holds.
- tc = en & (up_dn ? all digits ==9 : all digits ==0).
  - Purely combinational from en, up_dn and bcd_out.
  - The next stage's en connects to tc.
- Latency: bcd_out updates on the same edge the step, load or clear is sampled. There is no pipeline delay.
- Widths: digit arithmetic is 4-bit. No intermediate value outside 0..9 is ever visible on bcd_out.
- up_dn changing while en=0 has no effect. The direction is taken from the cycle in which the step occurs.

Test Plan (DIGITS=4 unless noted):
1. Reset, then en=1, up_dn=1 for 10 cycles -> bcd_out 0x0000, 0x0001 .. 0x0009, then 0x0010; ovf=0, tc=0 throughout.
2. Load 0x0999, en=1 up one cycle -> bcd_out 0x1000. Load 0x1000, en=1 down one cycle -> 0x0999.
3. SATURATE=0: load 0x9999, en=1, up_dn=1 -> tc=1 before the edge; after the edge bcd_out=0x0000 and ovf=1; ovf stays 1 while counting continues. Then down from 0x0000 -> 0x9999.
4. SATURATE=1: load 0x9999, en=1 up for 3 cycles -> bcd_out stays 0x9999, ovf=1. Load 0x0000, en=1 down -> stays 0x0000, ovf=1.
5. Load 0x1AF4 -> bcd_out 0x1994, load_err=1 for one cycle then 0. A later load of 0x1234 -> 0x1234, load_err=0, ovf=0.
6. At 0x0042 assert clear, load (0x5555) and en together -> bcd_out 0x0000. Then pull reset low mid-count at 0x0317, between edges -> immediate 0x0000 with ovf=0. After reset deasserts, counting up resumes from 0x0001.
